// File: rtl/id_stage_param.sv
// Instruction-decode stage: register file, decoder, load-use hazard detection and ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle WB write onto the rs/rt operands.
module id_stage_param #(
    parameter int D_WIDTH    = 32,
    parameter int NUM_REGS   = 32,
    parameter int HAZARD_DET = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        inst,
    input  logic [31:0]        pc4_in,
    output logic               in_ready,
    input  logic               ex_stall,
    input  logic               flush,
    input  logic               wb_we,
    input  logic [4:0]         wb_addr,
    input  logic [D_WIDTH-1:0] wb_data,
    output logic               out_valid,
    output logic [31:0]        pc4_out,
    output logic [5:0]         opcode_out,
    output logic [D_WIDTH-1:0] rs_val,
    output logic [D_WIDTH-1:0] rt_val,
    output logic [4:0]         rd_addr,
    output logic [D_WIDTH-1:0] imm_out,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               halted,
    output logic               hazard_stall
);

    localparam logic [5:0] OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03;
    localparam logic [5:0] OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07;
    localparam logic [5:0] OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10, OP_HALT = 6'h11;

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc4;
        logic [5:0]         opcode;
        logic [D_WIDTH-1:0] rs_val;
        logic [D_WIDTH-1:0] rt_val;
        logic [4:0]         rd;
        logic [D_WIDTH-1:0] imm;
        logic               branch;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
    } idex_t;

    function automatic logic idx_legal(input logic [4:0] idx);
        return (idx != 5'd0) && ({27'd0, idx} < 32'(NUM_REGS));
    endfunction

    // Storage is sized for the full 5-bit index space; entries at or above NUM_REGS are never written.
    logic [D_WIDTH-1:0] regs_q [32];
    logic [D_WIDTH-1:0] regs_d [32];
    idex_t              idex_q, idex_d, dec;
    logic               halted_q, halted_d;

    logic [5:0]         op;
    logic [4:0]         rs_idx, rt_idx;
    logic               use_rs, use_rt, is_halt, wb_legal, accept;
    logic [D_WIDTH-1:0] rs_fetch, rt_fetch;

    assign op       = inst[31:26];
    assign rs_idx   = inst[25:21];
    assign rt_idx   = inst[20:16];
    assign wb_legal = wb_we && idx_legal(wb_addr);

    always_comb begin
        regs_d = regs_q;
        if (wb_legal) regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        rs_fetch = '0;
        rt_fetch = '0;
        if (idx_legal(rs_idx)) rs_fetch = regs_q[rs_idx];
        if (idx_legal(rt_idx)) rt_fetch = regs_q[rt_idx];
`ifdef ID_WB_BYPASS_EN
        if (wb_legal && (wb_addr == rs_idx)) rs_fetch = wb_data;
        if (wb_legal && (wb_addr == rt_idx)) rt_fetch = wb_data;
`endif
    end

    always_comb begin
        dec     = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_halt = 1'b0;
        dec.pc4    = pc4_in;
        dec.opcode = op;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dec.rd = inst[15:11];
                dec.mem_to_reg = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI, OP_LDW: begin
                use_rs = 1'b1;
                dec.rd = rt_idx;
                dec.imm = {{(D_WIDTH-16){inst[15]}}, inst[15:0]};
                dec.mem_to_reg = 1'b1;
                dec.mem_read = (op == OP_LDW);
            end
            OP_STW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dec.imm = {{(D_WIDTH-16){inst[15]}}, inst[15:0]};
                dec.mem_write = 1'b1;
            end
            OP_BZ, OP_BEQ: begin
                use_rs = 1'b1;
                use_rt = (op == OP_BEQ);
                dec.imm = {{(D_WIDTH-16){inst[15]}}, inst[15:0]};
                dec.branch = 1'b1;
            end
            OP_JR: begin
                use_rs = 1'b1;
                dec.branch = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
        dec.rs_val = use_rs ? rs_fetch : '0;
        dec.rt_val = use_rt ? rt_fetch : '0;
    end

    always_comb begin
        hazard_stall = (HAZARD_DET != 0) && in_valid && idex_q.valid && idex_q.mem_read &&
                       (idex_q.rd != 5'd0) &&
                       ((use_rs && (rs_idx == idex_q.rd)) || (use_rt && (rt_idx == idex_q.rd)));
        in_ready = !ex_stall && !halted_q && !hazard_stall;
        accept   = in_valid && in_ready;
    end

    // Flush beats stall beats accept; anything else drains a bubble into EX.
    always_comb begin
        idex_d   = idex_q;
        halted_d = halted_q;
        if (flush) begin
            idex_d = '0;
        end else if (ex_stall) begin
            idex_d = idex_q;
        end else if (accept) begin
            idex_d       = dec;
            idex_d.valid = 1'b1;
            if (is_halt) halted_d = 1'b1;
        end else begin
            idex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            idex_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            idex_q   <= idex_d;
            halted_q <= halted_d;
        end
    end

    assign out_valid  = idex_q.valid;
    assign pc4_out    = idex_q.pc4;
    assign opcode_out = idex_q.opcode;
    assign rs_val     = idex_q.rs_val;
    assign rt_val     = idex_q.rt_val;
    assign rd_addr    = idex_q.rd;
    assign imm_out    = idex_q.imm;
    assign branch     = idex_q.branch;
    assign mem_read   = idex_q.mem_read;
    assign mem_to_reg = idex_q.mem_to_reg;
    assign mem_write  = idex_q.mem_write;
    assign halted     = halted_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param (NUM_REGS=8 so out-of-range register indices are exercised).
module tb_id_stage_param;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   inst;
    logic [31:0]   pc4_in;
    logic          in_ready;
    logic          ex_stall;
    logic          flush;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic [31:0]   pc4_out;
    logic [5:0]    opcode_out;
    logic [DW-1:0] rs_val, rt_val, imm_out;
    logic [4:0]    rd_addr;
    logic          branch, mem_read, mem_to_reg, mem_write, halted, hazard_stall;

    int n_vec = 0;
    int n_err = 0;

    id_stage_param #(.D_WIDTH(DW), .NUM_REGS(8), .HAZARD_DET(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .inst(inst), .pc4_in(pc4_in),
        .in_ready(in_ready), .ex_stall(ex_stall), .flush(flush), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .pc4_out(pc4_out),
        .opcode_out(opcode_out), .rs_val(rs_val), .rt_val(rt_val), .rd_addr(rd_addr),
        .imm_out(imm_out), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .halted(halted), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
        in_valid = v;
        inst     = i;
        pc4_in   = p;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    logic [31:0] byp_exp;

    initial begin
`ifdef ID_WB_BYPASS_EN
        byp_exp = 32'h1234;
`else
        byp_exp = 32'h0;
`endif
        reset = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rd_addr", rd_addr, 0);
        reset = 1'b1;
        @(negedge clk);

        // addi r1,r0,-5
        drive(1'b1, 32'h0401FFFB, 32'h4);
        #1 chk("addi_in_ready", in_ready, 1);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", rd_addr, 1);
        chk("addi_imm", imm_out, 32'hFFFFFFFB);
        chk("addi_m2r", mem_to_reg, 1);
        chk("addi_opcode", opcode_out, 6'h01);
        chk("addi_pc4", pc4_out, 32'h4);
        chk("addi_mem_read", mem_read, 0);

        // WB r3=0x1234 alongside add r4,r3,r3
        wb(1'b1, 5'd3, 32'h1234);
        drive(1'b1, 32'h00632000, 32'h8);
        tick();
        chk("add_same_rs", rs_val, byp_exp);
        chk("add_same_rt", rt_val, byp_exp);
        chk("add_rd", rd_addr, 4);
        chk("add_imm", imm_out, 0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("add_next_rs", rs_val, 32'h1234);
        chk("add_next_rt", rt_val, 32'h1234);

        // Idle cycle writing r1=0x10: ID/EX drains a bubble
        drive(1'b0, 32'h0, 32'h0);
        wb(1'b1, 5'd1, 32'h10);
        tick();
        chk("idle_bubble", out_valid, 0);
        wb(1'b0, 5'd0, 32'h0);

        // ldw r2,0(r1) then add r5,r2,r1: load-use bubble
        drive(1'b1, 32'h30220000, 32'hC);
        tick();
        chk("ldw_valid", out_valid, 1);
        chk("ldw_mem_read", mem_read, 1);
        chk("ldw_rd", rd_addr, 2);
        chk("ldw_rs", rs_val, 32'h10);
        drive(1'b1, 32'h00412800, 32'h10);
        #1;
        chk("lu_hazard", hazard_stall, 1);
        chk("lu_in_ready", in_ready, 0);
        tick();
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_mem_read", mem_read, 0);
        chk("lu_hazard_clear", hazard_stall, 0);
        chk("lu_ready_again", in_ready, 1);
        tick();
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_rd", rd_addr, 5);
        chk("lu_add_rt", rt_val, 32'h10);

        // ldw r2 then addi r6,r3,7: no dependency, no stall
        drive(1'b1, 32'h30220000, 32'h14);
        tick();
        drive(1'b1, 32'h04660007, 32'h18);
        #1 chk("nodep_hazard", hazard_stall, 0);
        tick();
        chk("nodep_valid", out_valid, 1);
        chk("nodep_rs", rs_val, 32'h1234);
        chk("nodep_rd", rd_addr, 6);
        chk("nodep_imm", imm_out, 32'h7);

        // beq r3,r1,8 then hold under ex_stall for 3 cycles
        drive(1'b1, 32'h3C610008, 32'h1C);
        tick();
        chk("beq_branch", branch, 1);
        chk("beq_rs", rs_val, 32'h1234);
        chk("beq_rt", rt_val, 32'h10);
        chk("beq_rd", rd_addr, 0);
        ex_stall = 1'b1;
        drive(1'b1, 32'h04660007, 32'h20);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_branch", branch, 1);
            chk("stall_hold_rs", rs_val, 32'h1234);
            chk("stall_hold_pc4", pc4_out, 32'h1C);
        end
        flush = 1'b1;
        tick();
        chk("flush_stall_valid", out_valid, 0);
        chk("flush_stall_branch", branch, 0);
        ex_stall = 1'b0;

        // HALT with flush is blocked
        drive(1'b1, 32'h44000000, 32'h24);
        tick();
        chk("flush_halt_halted", halted, 0);
        chk("flush_halt_valid", out_valid, 0);
        flush = 1'b0;

        // HALT accepted
        tick();
        chk("halt_valid", out_valid, 1);
        chk("halt_halted", halted, 1);
        chk("halt_m2r", mem_to_reg, 0);
        chk("halt_branch", branch, 0);
        drive(1'b1, 32'h04660007, 32'h28);
        for (int i = 0; i < 11; i++) begin
            #1 chk("halt_in_ready", in_ready, 0);
            tick();
        end
        chk("halt_drain_valid", out_valid, 0);
        chk("halt_sticky", halted, 1);
        reset = 1'b0;
        #2;
        chk("rerst_halted", halted, 0);
        chk("rerst_in_ready", in_ready, 1);
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Register file cleared by reset; r0 and r9 (>= NUM_REGS) are not writable
        drive(1'b1, 32'h00632000, 32'h30);
        tick();
        chk("rerst_r3", rs_val, 0);
        drive(1'b0, 32'h0, 32'h0);
        wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        wb(1'b1, 5'd9, 32'hBEEF);
        tick();
        wb(1'b1, 5'd7, 32'hABCD);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h00093800, 32'h34);
        tick();
        chk("r0_read", rs_val, 0);
        chk("r9_read", rt_val, 0);
        drive(1'b1, 32'h00E00800, 32'h38);
        tick();
        chk("r7_read", rs_val, 32'hABCD);

        // stw r3,4(r1) and an undefined opcode
        drive(1'b1, 32'h34230004, 32'h3C);
        tick();
        chk("stw_mem_write", mem_write, 1);
        chk("stw_rd", rd_addr, 0);
        chk("stw_m2r", mem_to_reg, 0);
        chk("stw_imm", imm_out, 32'h4);
        drive(1'b1, 32'hFC00F800, 32'h40);
        tick();
        chk("nop_valid", out_valid, 1);
        chk("nop_rd", rd_addr, 0);
        chk("nop_m2r", mem_to_reg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
